// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I definitions for the pipeline core: opcode constants, load/store
// funct3 encodings, the M-stage state encoding, the store-encoding struct
// returned by the alignment unit, and a misalignment helper.
// No ports (package).

package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } m_state_e;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] wdata;
  } st_enc_t;

  // Halfword accesses need a[0]==0, word accesses need a[1:0]==0. Store
  // funct3 values SH/SW share encodings with LH/LW, so one check covers both.
  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((funct3 == LH) || (funct3 == LHU)) mis = addr_lo[0];
    else if (funct3 == LW)                 mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational byte-lane steering for the M stage.
//   Store side: st_funct3, st_addr_lo, st_data -> st_strb, st_wdata
//               (lane strobe and replicated write data).
//   Load side:  ld_funct3, ld_addr_lo, ld_rdata -> ld_data
//               (lane extraction plus sign/zero extension; unknown funct3 -> 0).

module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  function automatic st_enc_t store_enc(logic [2:0] f3, logic [1:0] a_lo, logic [31:0] d);
    st_enc_t r;
    r.strb  = 4'b0000;
    r.wdata = d;
    case (f3)
      SB: begin
        r.strb  = 4'b0001 << a_lo;
        r.wdata = {4{d[7:0]}};
      end
      SH: begin
        r.strb  = 4'b0011 << {a_lo[1], 1'b0};
        r.wdata = {2{d[15:0]}};
      end
      SW: r.strb = 4'b1111;
      default: r.strb = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(logic [2:0] f3, logic [1:0] a_lo, logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a_lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a_lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      LB:      r = {{24{b[7]}}, b};
      LBU:     r = {24'h0, b};
      LH:      r = {{16{h[15]}}, h};
      LHU:     r = {16'h0, h};
      LW:      r = rd;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  st_enc_t st_enc;

  always_comb begin
    st_enc   = store_enc(st_funct3, st_addr_lo, st_data);
    st_strb  = st_enc.strb;
    st_wdata = st_enc.wdata;
    ld_data  = load_ext(ld_funct3, ld_addr_lo, ld_rdata);
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// M stage of the RV32I pipeline. Captures the ALU stage outputs, issues one
// load/store at a time on a request/acknowledge bus, and hands the result to
// write-back (M_*) and back to the ALU stage (FWD_M_*).
// Ports:
//   CLK, RST (async, active-low)
//   STALL, FLUSH in; MEM_STALL out (bus transaction outstanding)
//   A_PC, A_INST, A_VALID, A_REG_D, A_REG_D_V (result / effective address),
//   A_STORE_DATA in
//   MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA out; MEM_ACK, MEM_RDATA in
//   M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V, M_MISALIGN out
//   FWD_M_VALID, FWD_M_REG_D, FWD_M_REG_D_V out
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stage holds a non-memory op, a bubble, or a misaligned access
// WAIT  | bus request outstanding, stage frozen until MEM_ACK
// DONE  | bus transaction complete, load data held in rdata_q

module mem_access
  import rv32i_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        MEM_STALL,
  input  logic [31:0] A_PC,
  input  logic [31:0] A_INST,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG_D,
  input  logic [31:0] A_REG_D_V,
  input  logic [31:0] A_STORE_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_MISALIGN,
  output logic        FWD_M_VALID,
  output logic [4:0]  FWD_M_REG_D,
  output logic [31:0] FWD_M_REG_D_V
);

  m_state_e state_q, state_d;
  logic     stage_ld;
  logic     ack_ld;

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic [4:0]  reg_d_q;
  logic [31:0] alu_q;
  logic        misalign_q;

  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_strb_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] rdata_q;

  logic [6:0]  a_op;
  logic [2:0]  a_f3;
  logic        a_is_load;
  logic        a_is_store;
  logic        a_is_mem;
  logic        a_mis;
  logic        a_go;
  logic        a_no_rd;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        m_is_load;
  logic        m_is_store;
  logic [31:0] m_result;

  assign a_op       = A_INST[6:0];
  assign a_f3       = A_INST[14:12];
  assign a_is_load  = (a_op == OP_LOAD);
  assign a_is_store = (a_op == OP_STORE);
  assign a_is_mem   = a_is_load || a_is_store;
  assign a_mis      = a_is_mem && is_misaligned(a_f3, A_REG_D_V[1:0]);
  assign a_go       = A_VALID && a_is_mem && !a_mis;
  assign a_no_rd    = a_is_store || (a_op == OP_BRANCH);

  lsu_align u_lsu_align (
    .st_funct3  (a_f3),
    .st_addr_lo (A_REG_D_V[1:0]),
    .st_data    (A_STORE_DATA),
    .ld_funct3  (inst_q[14:12]),
    .ld_addr_lo (alu_q[1:0]),
    .ld_rdata   (rdata_q),
    .st_strb    (st_strb),
    .st_wdata   (st_wdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // WAIT freezes the stage on its own rather than trusting the controller to
  // feed MEM_STALL back into STALL, so FLUSH can never drop an in-flight access.
  always_comb begin
    state_d  = state_q;
    stage_ld = 1'b0;
    ack_ld   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (!STALL) begin
          stage_ld = 1'b1;
          if (FLUSH)     state_d = IDLE;
          else if (a_go) state_d = WAIT;
          else           state_d = IDLE;
        end
      end
      WAIT: begin
        if (MEM_ACK) begin
          state_d = DONE;
          ack_ld  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q       <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      reg_d_q    <= '0;
      alu_q      <= '0;
      misalign_q <= 1'b0;
    end else if (stage_ld) begin
      if (FLUSH) begin
        pc_q       <= '0;
        inst_q     <= '0;
        valid_q    <= 1'b0;
        reg_d_q    <= '0;
        alu_q      <= '0;
        misalign_q <= 1'b0;
      end else begin
        pc_q       <= A_PC;
        inst_q     <= A_INST;
        valid_q    <= A_VALID;
        reg_d_q    <= a_no_rd ? 5'd0 : A_REG_D;
        alu_q      <= A_REG_D_V;
        misalign_q <= A_VALID && a_mis;
      end
    end
  end

  // Bus registers only change on the edge that enters WAIT, so they stay
  // stable for the whole request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_strb_q  <= '0;
      bus_wdata_q <= '0;
    end else if (stage_ld && !FLUSH && a_go) begin
      bus_we_q    <= a_is_store;
      bus_addr_q  <= {A_REG_D_V[31:2], 2'b00};
      bus_strb_q  <= st_strb;
      bus_wdata_q <= st_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        rdata_q <= '0;
    else if (ack_ld) rdata_q <= MEM_RDATA;
  end

  assign m_is_load  = (inst_q[6:0] == OP_LOAD);
  assign m_is_store = (inst_q[6:0] == OP_STORE);

  always_comb begin
    m_result = alu_q;
    if (misalign_q)      m_result = '0;
    else if (m_is_load)  m_result = (state_q == DONE) ? ld_data : '0;
    else if (m_is_store) m_result = '0;
  end

  assign MEM_REQ   = (state_q == WAIT);
  assign MEM_STALL = (state_q == WAIT);
  assign MEM_WE    = bus_we_q;
  assign MEM_ADDR  = bus_addr_q;
  assign MEM_STRB  = bus_strb_q;
  assign MEM_WDATA = bus_wdata_q;

  assign M_PC       = pc_q;
  assign M_INST     = inst_q;
  assign M_VALID    = valid_q && (state_q != WAIT);
  assign M_REG_D    = reg_d_q;
  assign M_REG_D_V  = m_result;
  assign M_MISALIGN = misalign_q;

  assign FWD_M_VALID   = M_VALID && (reg_d_q != 5'd0);
  assign FWD_M_REG_D   = reg_d_q;
  assign FWD_M_REG_D_V = m_result;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import rv32i_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_ext;
  logic        STALL;
  logic        FLUSH;
  logic        MEM_STALL;
  logic [31:0] A_PC, A_INST, A_REG_D_V, A_STORE_DATA;
  logic        A_VALID;
  logic [4:0]  A_REG_D;
  logic        MEM_REQ, MEM_WE, MEM_ACK;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [3:0]  MEM_STRB;
  logic [31:0] M_PC, M_INST, M_REG_D_V, FWD_M_REG_D_V;
  logic        M_VALID, M_MISALIGN, FWD_M_VALID;
  logic [4:0]  M_REG_D, FWD_M_REG_D;

  // Pipeline controller behaviour: MEM_STALL is ORed into STALL.
  assign STALL = stall_ext | MEM_STALL;

  mem_access dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .MEM_STALL(MEM_STALL),
    .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID), .A_REG_D(A_REG_D),
    .A_REG_D_V(A_REG_D_V), .A_STORE_DATA(A_STORE_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_STRB(MEM_STRB),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_MISALIGN(M_MISALIGN),
    .FWD_M_VALID(FWD_M_VALID), .FWD_M_REG_D(FWD_M_REG_D), .FWD_M_REG_D_V(FWD_M_REG_D_V)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        mis;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } bus_t;

  sb_t  sb_q[$];
  bus_t bus_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] pc_ctr = 32'h100;
  logic [31:0] last_pc = '1;
  bit   noise = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_mis(logic [2:0] f3, logic [31:0] a);
    if (f3 == 3'd1 || f3 == 3'd5) return a[0];
    if (f3 == 3'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_strb(logic [2:0] f3, logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      3'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return {24'h0, d[7:0]} * 32'h01010101;
      3'd1:    return {16'h0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b, h;
    int sb, sh;
    sb = 8 * int'(a % 4);
    sh = ((a % 4) >= 2) ? 16 : 0;
    b = (rd >> sb) & 32'hFF;
    h = (rd >> sh) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      3'd2:    return rd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mk(logic [6:0] op, logic [2:0] f3);
    return {17'($urandom), f3, 5'($urandom), op};
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(logic [31:0] inst, logic [4:0] rd, logic [31:0] a,
                       logic [31:0] d, logic [31:0] rdata, int delay);
    int guard;
    bit is_ld, is_st, mis;
    sb_t e;
    bus_t b;
    guard = 0;
    @(negedge CLK);
    while (STALL) begin
      @(negedge CLK);
      guard++;
      if (guard > 200) begin
        n_checks++;
        $display("FAIL issue_timeout: STALL still high after %0d cycles", guard);
        return;
      end
    end
    pc_ctr = pc_ctr + 4;
    A_PC = pc_ctr; A_INST = inst; A_REG_D = rd; A_REG_D_V = a;
    A_STORE_DATA = d; A_VALID = 1'b1;
    is_ld = (inst[6:0] == OP_LOAD);
    is_st = (inst[6:0] == OP_STORE);
    mis = (is_ld || is_st) && model_mis(inst[14:12], a);
    e.pc = pc_ctr;
    e.inst = inst;
    e.rd = (is_st || inst[6:0] == OP_BRANCH) ? 5'd0 : rd;
    e.mis = mis;
    e.val = mis ? 32'h0 : is_ld ? model_load(inst[14:12], a, rdata) : is_st ? 32'h0 : a;
    if (!FLUSH) begin
      sb_q.push_back(e);
      if ((is_ld || is_st) && !mis) begin
        b.addr = a - (a % 4);
        b.we = is_st;
        b.strb = model_strb(inst[14:12], a);
        b.wdata = model_wdata(inst[14:12], d);
        b.rdata = rdata;
        b.delay = delay;
        bus_q.push_back(b);
      end
    end
    @(posedge CLK);
    #1 A_VALID = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || bus_q.size() != 0) && g < 300) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 300) begin
      n_checks++;
      $display("FAIL drain_timeout: pending results %0d bus %0d", sb_q.size(), bus_q.size());
    end
    @(negedge CLK);
  endtask

  // ---------------- result monitor ----------------
  initial begin
    sb_t e;
    forever begin
      @(negedge CLK);
      if (!RST) last_pc = '1;
      else if (M_VALID && M_PC !== last_pc) begin
        last_pc = M_PC;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: pc %h with no expectation", M_PC);
        end else begin
          e = sb_q.pop_front();
          chk("m_pc", M_PC, e.pc);
          chk("m_inst", M_INST, e.inst);
          chk("m_reg_d", {27'h0, M_REG_D}, {27'h0, e.rd});
          chk("m_reg_d_v", M_REG_D_V, e.val);
          chk("m_misalign", {31'h0, M_MISALIGN}, {31'h0, e.mis});
          chk("fwd_valid", {31'h0, FWD_M_VALID}, {31'h0, e.rd != 5'd0});
          chk("fwd_reg_d", {27'h0, FWD_M_REG_D}, {27'h0, e.rd});
          chk("fwd_reg_d_v", FWD_M_REG_D_V, e.val);
        end
      end
    end
  end

  // ---------------- bus slave / bus monitor ----------------
  initial begin
    bus_t b;
    bit aborted;
    MEM_ACK = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      if (RST && MEM_REQ) begin
        MEM_ACK = 1'b0;
        if (bus_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bus_req: addr %h we %b", MEM_ADDR, MEM_WE);
          MEM_ACK = 1'b1;
          @(negedge CLK);
          MEM_ACK = 1'b0;
        end else begin
          b = bus_q.pop_front();
          aborted = 1'b0;
          for (int k = 1; k <= b.delay; k++) begin
            if (!(RST && MEM_REQ)) begin
              aborted = 1'b1;
              break;
            end
            chk("bus_addr", MEM_ADDR, b.addr);
            chk("bus_we", {31'h0, MEM_WE}, {31'h0, b.we});
            chk("stall_in_wait", {31'h0, MEM_STALL}, 32'h1);
            chk("fwd_valid_in_wait", {31'h0, FWD_M_VALID}, 32'h0);
            if (b.we) begin
              chk("bus_strb", {28'h0, MEM_STRB}, {28'h0, b.strb});
              chk("bus_wdata", MEM_WDATA, b.wdata);
            end
            if (k < b.delay) @(negedge CLK);
          end
          if (!aborted) begin
            MEM_ACK = 1'b1;
            MEM_RDATA = b.rdata;
            @(negedge CLK);
            MEM_ACK = 1'b0;
            if (RST) chk("req_after_ack", {31'h0, MEM_REQ}, 32'h0);
          end
        end
      end else begin
        MEM_ACK = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        MEM_RDATA = $urandom;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] held_pc;
    int kind;
    logic [2:0] f3;
    logic [6:0] op;
    logic [31:0] a;
    logic [2:0] ld_f3_tab[7];
    ld_f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    RST = 1'b0; stall_ext = 1'b0; FLUSH = 1'b0;
    A_PC = '0; A_INST = '0; A_VALID = 1'b0; A_REG_D = '0; A_REG_D_V = '0; A_STORE_DATA = '0;
    #12;
    chk("rst_mem_req", {31'h0, MEM_REQ}, 32'h0);
    chk("rst_mem_stall", {31'h0, MEM_STALL}, 32'h0);
    chk("rst_m_valid", {31'h0, M_VALID}, 32'h0);
    chk("rst_fwd_valid", {31'h0, FWD_M_VALID}, 32'h0);
    chk("rst_m_reg_d_v", M_REG_D_V, 32'h0);
    chk("rst_m_misalign", {31'h0, M_MISALIGN}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // addi x5 = 0x1234
    issue(mk(OP_OPIMM, 3'd0), 5'd5, 32'h1234, 32'h0, 32'h0, 1);
    chk("addi_no_req", {31'h0, MEM_REQ}, 32'h0);
    // SB at 0x1003, three wait cycles
    issue(mk(OP_STORE, SB), 5'd11, 32'h1003, 32'hAABBCCDD, 32'h0, 3);
    // loads with extension
    issue(mk(OP_LOAD, LB), 5'd7, 32'h2001, 32'h0, 32'h000080FF, 1);
    issue(mk(OP_LOAD, LBU), 5'd8, 32'h2001, 32'h0, 32'h000080FF, 2);
    issue(mk(OP_LOAD, LHU), 5'd9, 32'h2002, 32'h0, 32'h80010000, 1);
    issue(mk(OP_LOAD, LH), 5'd10, 32'h2002, 32'h0, 32'h80010000, 1);
    drain();
    // misaligned LW: no bus request, stays idle
    issue(mk(OP_LOAD, LW), 5'd9, 32'h3002, 32'h0, 32'h12345678, 1);
    chk("misalign_no_req", {31'h0, MEM_REQ}, 32'h0);
    chk("misalign_no_stall", {31'h0, MEM_STALL}, 32'h0);
    issue(mk(OP_STORE, SH), 5'd9, 32'h3005, 32'h5555AAAA, 32'h0, 1);
    drain();

    // FLUSH during WAIT is ignored
    issue(mk(OP_LOAD, LW), 5'd12, 32'h4000, 32'h0, 32'hCAFEF00D, 5);
    FLUSH = 1'b1;
    drain();
    FLUSH = 1'b0;

    // FLUSH on a capture edge turns the op into a bubble
    FLUSH = 1'b1;
    issue(mk(OP_OPIMM, 3'd0), 5'd13, 32'hDEAD0001, 32'h0, 32'h0, 1);
    FLUSH = 1'b0;
    issue(mk(OP_OPIMM, 3'd0), 5'd14, 32'h00000077, 32'h0, 32'h0, 1);
    drain();

    // STALL wins over FLUSH, then FLUSH clears the stage
    issue(mk(OP_OPIMM, 3'd0), 5'd3, 32'h55, 32'h0, 32'h0, 1);
    held_pc = pc_ctr;
    stall_ext = 1'b1; FLUSH = 1'b1;
    @(negedge CLK); @(negedge CLK);
    chk("stall_hold_valid", {31'h0, M_VALID}, 32'h1);
    chk("stall_hold_pc", M_PC, held_pc);
    chk("stall_hold_val", M_REG_D_V, 32'h55);
    stall_ext = 1'b0;
    @(negedge CLK);
    chk("flush_bubble_valid", {31'h0, M_VALID}, 32'h0);
    chk("flush_bubble_pc", M_PC, 32'h0);
    FLUSH = 1'b0;

    // back-to-back LWs, immediate ACK; x0 destination never forwarded
    issue(mk(OP_LOAD, LW), 5'd0, 32'h5000, 32'h0, 32'h11111111, 1);
    issue(mk(OP_LOAD, LW), 5'd4, 32'h5004, 32'h0, 32'h22222222, 1);
    drain();

    // reset in the middle of WAIT
    issue(mk(OP_LOAD, LW), 5'd6, 32'h6000, 32'h0, 32'h33333333, 10);
    @(negedge CLK); @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rst_wait_mem_req", {31'h0, MEM_REQ}, 32'h0);
    chk("rst_wait_m_valid", {31'h0, M_VALID}, 32'h0);
    chk("rst_wait_mem_stall", {31'h0, MEM_STALL}, 32'h0);
    sb_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    bus_q.delete();

    // randomized traffic with spurious ACKs while idle
    noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if (kind < 3) begin
        op = OP_OPIMM; f3 = 3'($urandom);
      end else if (kind < 4) begin
        op = OP_BRANCH; f3 = 3'($urandom);
      end else if (kind < 7) begin
        op = OP_LOAD; f3 = ld_f3_tab[$urandom_range(0, 6)];
      end else begin
        op = OP_STORE; f3 = 3'($urandom_range(0, 2));
      end
      issue(mk(op, f3), 5'($urandom), a, $urandom, $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        stall_ext = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge CLK);
        stall_ext = 1'b0;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
